dmem_arbiter: RTL

// - Shares the single main port of data_memory between the core load/store path (CPU) and the

---
 rtl/dmem_arbiter_pkg.sv | 29 ++
 rtl/dmem_arbiter_lsu_align.sv | 53 +++++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter and its lane aligner.
package dmem_arbiter_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      DARB_IDLE   = 2'd0,
      DARB_ACCESS = 2'd1,
      DARB_RESP   = 2'd2
   } darb_state_e;

   typedef enum logic {
      DARB_GNT_CPU = 1'b0,
      DARB_GNT_DBG = 1'b1
   } darb_gnt_e;

   // Loads allow 000/001/010/100/101; stores only 000/001/010.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      return (f3[1:0] == 2'b11) || (f3[2] && (we || f3[1]));
   endfunction

endpackage

// File: rtl/dmem_arbiter_lsu_align.sv
// RV32 lane handling: store byte-enables/data replication, load extraction
// and sign/zero extension, plus misalignment and illegal-funct3 detection.
module dmem_arbiter_lsu_align
   import dmem_arbiter_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] word,
   output logic [3:0]  byte_enable,
   output logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        err
);

   logic [31:0] shifted;
   logic        misalign;

   assign shifted = word >> {offset, 3'b000};

   always_comb begin
      byte_enable = 4'b0000;
      store_data  = 32'h0;
      load_data   = 32'h0;
      misalign    = 1'b0;
      unique case (funct3[1:0])
         2'b00: begin
            byte_enable = 4'b0001 << offset;
            store_data  = {4{wdata[7:0]}};
            load_data   = funct3[2] ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            byte_enable = 4'b0011 << offset;
            store_data  = {2{wdata[15:0]}};
            load_data   = funct3[2] ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
            misalign    = offset[0];
         end
         2'b10: begin
            byte_enable = 4'b1111;
            store_data  = wdata;
            load_data   = word;
            misalign    = |offset;
         end
         default: ;
      endcase
   end

   assign err = misalign || f3_illegal(we, funct3);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and debug access to the single data_memory port and
// runs each transaction through IDLE -> ACCESS -> RESP.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int MEM_BYTES    = 4096,
   parameter int DBG_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic              cpu_we,
   input  logic [2:0]        cpu_funct3,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_resp_valid,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_resp_err,
   input  logic              dbg_req_valid,
   output logic              dbg_req_ready,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [31:0]       dbg_wdata,
   output logic              dbg_resp_valid,
   output logic [31:0]       dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data_in,
   output logic              mem_read_en,
   output logic              mem_write_en,
   output logic [3:0]        mem_byte_enable,
   input  logic [31:0]       mem_data_out
);

   darb_state_e       state;
   darb_gnt_e         gnt;
   logic              req_we;
   logic [2:0]        req_f3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic              idle;
   logic              pick_dbg;
   logic [1:0]        offset;
   logic [3:0]        la_be;
   logic [31:0]       la_sd;
   logic [31:0]       la_ld;
   logic              la_err;
   logic              err;
   logic              access;
   logic              resp;
   logic              go;

   assign idle = (state == DARB_IDLE) && !reset;

   // On a tie the requester not granted last wins, unless DBG is prioritised.
   always_comb begin
      pick_dbg = 1'b0;
      if (dbg_req_valid && !cpu_req_valid)
         pick_dbg = 1'b1;
      else if (dbg_req_valid && cpu_req_valid)
         pick_dbg = (DBG_PRIORITY != 0) || (gnt == DARB_GNT_CPU);
   end

   assign cpu_req_ready = idle && cpu_req_valid && !pick_dbg;
   assign dbg_req_ready = idle && dbg_req_valid && pick_dbg;

   // Debug accesses are whole words; their low address bits are ignored.
   assign offset = (gnt == DARB_GNT_DBG) ? 2'b00 : req_addr[1:0];

   dmem_arbiter_lsu_align u_align (
      .we          (req_we),
      .funct3      (req_f3),
      .offset      (offset),
      .wdata       (req_wdata),
      .word        (mem_data_out),
      .byte_enable (la_be),
      .store_data  (la_sd),
      .load_data   (la_ld),
      .err         (la_err)
   );

   assign err    = la_err || (req_addr >= ADDR_W'(MEM_BYTES));
   assign access = (state == DARB_ACCESS);
   assign resp   = (state == DARB_RESP);
   assign go     = access && !err;

   assign mem_addr        = access ? {req_addr[ADDR_W-1:2], 2'b00} : '0;
   assign mem_read_en     = go && !req_we;
   assign mem_write_en    = go && req_we;
   assign mem_data_in     = (go && req_we) ? la_sd : 32'h0;
   assign mem_byte_enable = !go ? 4'b0000 : (req_we ? la_be : 4'b1111);

   assign cpu_resp_valid = resp && (gnt == DARB_GNT_CPU);
   assign cpu_resp_err   = cpu_resp_valid && err;
   assign cpu_rdata      = (cpu_resp_valid && !err && !req_we) ? la_ld : 32'h0;
   assign dbg_resp_valid = resp && (gnt == DARB_GNT_DBG);
   assign dbg_rdata      = (dbg_resp_valid && !err && !req_we) ? la_ld : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= DARB_IDLE;
         gnt       <= DARB_GNT_DBG;
         req_we    <= 1'b0;
         req_f3    <= 3'b000;
         req_addr  <= '0;
         req_wdata <= 32'h0;
      end else begin
         unique case (state)
            DARB_IDLE: begin
               unique case (1'b1)
                  cpu_req_ready: begin
                     req_we    <= cpu_we;
                     req_f3    <= cpu_funct3;
                     req_addr  <= cpu_addr;
                     req_wdata <= cpu_wdata;
                     gnt       <= DARB_GNT_CPU;
                     state     <= DARB_ACCESS;
                  end
                  dbg_req_ready: begin
                     req_we    <= dbg_we;
                     req_f3    <= F3_LW;
                     req_addr  <= dbg_addr;
                     req_wdata <= dbg_wdata;
                     gnt       <= DARB_GNT_DBG;
                     state     <= DARB_ACCESS;
                  end
                  default: ;
               endcase
            end
            DARB_ACCESS: state <= DARB_RESP;
            DARB_RESP:   state <= DARB_IDLE;
            default:     state <= DARB_IDLE;
         endcase
      end
   end

endmodule
